pac_move_ctrl: RTL and testbench

- Sequences the Pac-Man sprite's tile position (pac_x, pac_y) on the 21-pixel tile maze grid, one step per movement tick.
- Buffers the player's requested turn and queries the registered maze wall ROM for the target tile before each step.
- Implements tunnel wrap-around and freezes on gameover.
- Its pac_x/pac_y outputs feed the sprite renderer and the collision logic.

---
 rtl/pac_move_ctrl.sv | 149 ++++++++++++++
 tb/tb_pac_move_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pac_move_ctrl.sv
// Pac-Man tile movement sequencer: one step per movement tick, with a buffered turn
// request checked against the registered wall ROM before the straight-ahead fallback.
module pac_move_ctrl #(
  parameter int MAZE_W   = 21,
  parameter int MAZE_H   = 21,
  parameter int START_X  = 10,
  parameter int START_Y  = 15,
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       gameover,
  input  logic [3:0] dir_req,
  output logic [4:0] wall_qx,
  output logic [4:0] wall_qy,
  input  logic       wall_hit,
  output logic [4:0] pac_x,
  output logic [4:0] pac_y,
  output logic [1:0] pac_dir,
  output logic       moved
);

  // state  | meaning
  // S_WAIT | idle at current tile, waiting for a movement tick
  // S_QP   | present the pending-turn target to the wall ROM
  // S_CP   | sample wall_hit for the pending-turn target
  // S_QC   | present the straight-ahead target to the wall ROM
  // S_CC   | sample wall_hit for the straight-ahead target
  typedef enum logic [2:0] {S_WAIT, S_QP, S_CP, S_QC, S_CC} state_t;

  localparam int          CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC  = CW'(TICK_DIV - 1);
  localparam logic [4:0]  XMAX  = 5'(MAZE_W - 1);
  localparam logic [4:0]  YMAX  = 5'(MAZE_H - 1);
  localparam logic [1:0]  DIR_R = 2'b00;
  localparam logic [1:0]  DIR_L = 2'b01;
  localparam logic [1:0]  DIR_U = 2'b10;
  localparam logic [1:0]  DIR_D = 2'b11;

  state_t        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          pend_valid_q;
  logic [1:0]    pend_dir_q;
  logic [4:0]    pac_x_q, pac_y_q;
  logic [1:0]    pac_dir_q;
  logic          moved_q;
  logic          req_ok;
  logic [1:0]    req_dir;
  logic [9:0]    tgt_p, tgt_c;

  // Wrap compares use the maze size, not 5-bit overflow, so edges wrap inside the maze.
  function automatic logic [9:0] neighbor(input logic [4:0] x, input logic [4:0] y,
                                          input logic [1:0] d);
    logic [4:0] nx, ny;
    nx = x;
    ny = y;
    case (d)
      DIR_R:   nx = (x == XMAX) ? 5'd0 : x + 5'd1;
      DIR_L:   nx = (x == 5'd0) ? XMAX : x - 5'd1;
      DIR_U:   ny = (y == 5'd0) ? YMAX : y - 5'd1;
      default: ny = (y == YMAX) ? 5'd0 : y + 5'd1;
    endcase
    return {nx, ny};
  endfunction

  assign tick  = (cnt_q == TC);
  assign cnt_d = gameover ? '0 : (tick ? '0 : cnt_q + 1'b1);

  always_comb begin
    req_ok  = 1'b1;
    req_dir = DIR_R;
    case (dir_req)
      4'b0001: req_dir = DIR_R;
      4'b0010: req_dir = DIR_L;
      4'b0100: req_dir = DIR_D;
      4'b1000: req_dir = DIR_U;
      default: req_ok  = 1'b0;
    endcase
  end

  assign tgt_p = neighbor(pac_x_q, pac_y_q, pend_dir_q);
  assign tgt_c = neighbor(pac_x_q, pac_y_q, pac_dir_q);

  always_comb begin
    {wall_qx, wall_qy} = {pac_x_q, pac_y_q};
    case (state_q)
      S_QP, S_CP: {wall_qx, wall_qy} = tgt_p;
      S_QC, S_CC: {wall_qx, wall_qy} = tgt_c;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_R;
      pac_x_q      <= 5'(START_X);
      pac_y_q      <= 5'(START_Y);
      pac_dir_q    <= DIR_L;
      moved_q      <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      moved_q <= 1'b0;
      if (req_ok && !gameover) begin
        pend_valid_q <= 1'b1;
        pend_dir_q   <= req_dir;
      end
      if (gameover) begin
        state_q      <= S_WAIT;
        pend_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_WAIT: if (tick) state_q <= pend_valid_q ? S_QP : S_QC;
          S_QP:   state_q <= S_CP;
          S_CP: begin
            if (!wall_hit) begin
              {pac_x_q, pac_y_q} <= tgt_p;
              pac_dir_q          <= pend_dir_q;
              moved_q            <= 1'b1;
              state_q            <= S_WAIT;
              // a fresh request arriving now replaces the consumed one
              if (!req_ok) pend_valid_q <= 1'b0;
            end else begin
              state_q <= S_QC;
            end
          end
          S_QC:   state_q <= S_CC;
          S_CC: begin
            if (!wall_hit) begin
              {pac_x_q, pac_y_q} <= tgt_c;
              moved_q            <= 1'b1;
            end
            state_q <= S_WAIT;
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign pac_x   = pac_x_q;
  assign pac_y   = pac_y_q;
  assign pac_dir = pac_dir_q;
  assign moved   = moved_q;

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed bench for pac_move_ctrl with TICK_DIV=8 and a 1-cycle-latency wall map.
module tb_pac_move_ctrl;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       gameover = 1'b0;
  logic [3:0] dir_req = 4'b0000;
  logic [4:0] wall_qx, wall_qy, pac_x, pac_y;
  logic       wall_hit;
  logic [1:0] pac_dir;
  logic       moved;
  logic       wall_map [0:31][0:31];
  int         n_assert = 0;
  int         n_fail = 0;

  pac_move_ctrl #(.MAZE_W(21), .MAZE_H(21), .START_X(10), .START_Y(15), .TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n), .gameover(gameover), .dir_req(dir_req),
    .wall_qx(wall_qx), .wall_qy(wall_qy), .wall_hit(wall_hit),
    .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir), .moved(moved)
  );

  always #5 clk = ~clk;

  always @(posedge clk) wall_hit <= wall_map[wall_qx][wall_qy];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_map();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        wall_map[i][j] = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] d);
    dir_req = d;
    cyc(1);
    dir_req = 4'b0000;
  endtask

  // leaves the bench at the falling edge inside the tick cycle
  task automatic wait_tick();
    int k;
    k = 0;
    while (dut.cnt_q != 3'(TD - 1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_fail++;
      $error("FAIL tick_timeout: observed no tick in %0d cycles expected tick", k);
    end
  endtask

  task automatic step_free();
    wait_tick();
    cyc(3);
  endtask

  initial begin
    clear_map();
    reset_n = 1'b0;
    cyc(3);
    check("rst_x", pac_x, 10);
    check("rst_y", pac_y, 15);
    check("rst_dir", pac_dir, 1);
    check("rst_moved", moved, 0);
    check("rst_pend", dut.pend_valid_q, 0);
    check("rst_cnt", dut.cnt_q, 0);
    check("rst_state", dut.state_q, 0);

    // first tick lands in cycle 7 after release, step visible in cycle 10
    reset_n = 1'b1;
    cyc(9);
    check("t1_before_x", pac_x, 10);
    cyc(1);
    check("t1_x", pac_x, 9);
    check("t1_moved", moved, 1);
    cyc(1);
    check("t1_moved_drop", moved, 0);
    cyc(6);
    check("t2_before_x", pac_x, 9);
    cyc(1);
    check("t2_x", pac_x, 8);
    check("t2_moved", moved, 1);

    // buffered up-turn blocked twice, taken on the third tick
    wall_map[8][14] = 1'b1;
    wall_map[7][14] = 1'b1;
    pulse(4'b1000);
    check("buf_pend_set", dut.pend_valid_q, 1);
    wait_tick();
    cyc(4);
    check("blk_lat_x", pac_x, 8);
    cyc(1);
    check("blk1_x", pac_x, 7);
    check("blk1_y", pac_y, 15);
    check("blk1_dir", pac_dir, 1);
    check("blk1_pend", dut.pend_valid_q, 1);
    check("blk1_moved", moved, 1);
    wait_tick();
    cyc(5);
    check("blk2_x", pac_x, 6);
    check("blk2_pend", dut.pend_valid_q, 1);
    step_free();
    check("turn_x", pac_x, 6);
    check("turn_y", pac_y, 14);
    check("turn_dir", pac_dir, 2);
    check("turn_pend", dut.pend_valid_q, 0);

    // all four edge wraps on an empty map
    clear_map();
    pulse(4'b0010);
    step_free();
    check("left_x5", pac_x, 5);
    check("left_dir", pac_dir, 1);
    for (int i = 0; i < 5; i++) step_free();
    check("left_x0", pac_x, 0);
    step_free();
    check("wrap_left_x", pac_x, 20);
    pulse(4'b0001);
    step_free();
    check("wrap_right_x", pac_x, 0);
    check("wrap_right_dir", pac_dir, 0);
    pulse(4'b0100);
    step_free();
    check("down_y15", pac_y, 15);
    check("down_dir", pac_dir, 3);
    for (int i = 0; i < 5; i++) step_free();
    check("down_y20", pac_y, 20);
    step_free();
    check("wrap_down_y", pac_y, 0);
    pulse(4'b1000);
    step_free();
    check("wrap_up_y", pac_y, 20);
    check("wrap_up_x", pac_x, 0);
    check("wrap_up_dir", pac_dir, 2);

    // both pending and straight targets walled
    wall_map[0][19] = 1'b1;
    wall_map[1][20] = 1'b1;
    pulse(4'b0001);
    wait_tick();
    check("q_wait_x", wall_qx, 0);
    check("q_wait_y", wall_qy, 20);
    cyc(1);
    check("q_qp_x", wall_qx, 1);
    check("q_qp_y", wall_qy, 20);
    check("q_qp_moved", moved, 0);
    cyc(1);
    check("q_cp_x", wall_qx, 1);
    check("q_cp_y", wall_qy, 20);
    check("q_cp_moved", moved, 0);
    cyc(1);
    check("q_qc_x", wall_qx, 0);
    check("q_qc_y", wall_qy, 19);
    check("q_qc_moved", moved, 0);
    cyc(1);
    check("q_cc_x", wall_qx, 0);
    check("q_cc_y", wall_qy, 19);
    check("q_cc_moved", moved, 0);
    cyc(1);
    check("stuck_x", pac_x, 0);
    check("stuck_y", pac_y, 20);
    check("stuck_moved", moved, 0);
    check("stuck_pend", dut.pend_valid_q, 1);
    check("stuck_state", dut.state_q, 0);

    // gameover while sampling a free pending target
    clear_map();
    wait_tick();
    cyc(2);
    check("go_in_cp", dut.state_q, 2);
    gameover = 1'b1;
    cyc(1);
    check("go_x", pac_x, 0);
    check("go_y", pac_y, 20);
    check("go_moved", moved, 0);
    check("go_pend", dut.pend_valid_q, 0);
    check("go_cnt", dut.cnt_q, 0);
    check("go_state", dut.state_q, 0);
    dir_req = 4'b0001;
    cyc(1);
    dir_req = 4'b0000;
    check("go_req_ignored", dut.pend_valid_q, 0);
    cyc(2);
    gameover = 1'b0;
    cyc(TD + 1);
    check("go_rel_before_y", pac_y, 20);
    check("go_rel_before_moved", moved, 0);
    cyc(1);
    check("go_rel_y", pac_y, 19);
    check("go_rel_x", pac_x, 0);
    check("go_rel_moved", moved, 1);

    // reset mid-sequence during the straight query
    wait_tick();
    cyc(1);
    check("mid_in_qc", dut.state_q, 3);
    reset_n = 1'b0;
    cyc(1);
    check("mid_rst_x", pac_x, 10);
    check("mid_rst_y", pac_y, 15);
    check("mid_rst_dir", pac_dir, 1);
    check("mid_rst_state", dut.state_q, 0);
    check("mid_rst_moved", moved, 0);
    cyc(2);
    check("mid_rst_hold_y", pac_y, 15);
    reset_n = 1'b1;
    pulse(4'b0011);
    check("multi_req_ignored", dut.pend_valid_q, 0);
    step_free();
    check("post_rst_x", pac_x, 9);
    check("post_rst_y", pac_y, 15);
    check("post_rst_dir", pac_dir, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
